// File: rtl/oram_write_buffer.sv
// oram_write_buffer: FIFO-decoupled writer of translated ARM words into the output code RAM
//
// Words pushed by the translator are queued in a small FIFO. Each queued word is written
// to the code RAM at the next consecutive word address. One word is written every
// WR_CYCLES cycles. The block also counts the words written, reports end of method,
// and detects code-area overflow.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset, clears all state
//   i_start      push request, accepted when i_start && o_ready
//   i_data       32-bit ARM instruction word to store
//   o_ready      FIFO can accept this cycle (not full, not overflowed)
//   i_load_base  load i_base_addr into the write pointer (IDLE/HALT with FIFO empty only)
//   i_base_addr  start word address of the next method
//   i_flush      end of method; o_done pulses once every accepted word is written
//   o_mem_we     RAM write strobe, one cycle per word
//   o_mem_addr   RAM word address, valid with o_mem_we
//   o_mem_wdata  RAM write data, valid with o_mem_we
//   o_word_count words written since the last load_base or reset
//   o_done       one-cycle pulse: flush pending, FIFO empty, RAM idle
//   o_overflow   sticky: a word was due at an address beyond ADDR_LIMIT
module oram_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int AW         = 10,
    parameter int WR_CYCLES  = 2,
    parameter int ADDR_LIMIT = 1023
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [31:0]   i_data,
    output logic          o_ready,
    input  logic          i_load_base,
    input  logic [AW-1:0] i_base_addr,
    input  logic          i_flush,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic [AW:0]   o_word_count,
    output logic          o_done,
    output logic          o_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(WR_CYCLES + 1);
    localparam logic [AW:0] LIMIT = (AW+1)'(ADDR_LIMIT);
    localparam logic [CW-1:0] WAIT_INIT = CW'((WR_CYCLES > 1) ? WR_CYCLES - 2 : 0);
    // The write itself is not a registered state. Issuing straight from IDLE gives the
    // one-cycle accept-to-mem_we latency. WAIT covers the remaining RAM cycles.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [31:0]   r_mem [DEPTH];
    logic [PW:0]   r_wp;
    logic [PW:0]   r_rp;
    logic [AW:0]   r_ptr;
    logic [AW:0]   r_count;
    logic [CW-1:0] r_wcnt;
    logic [1:0]    r_state;
    logic          r_flush;
    logic          r_ovf;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_due;
    logic          w_hit;
    logic          w_issue;
    logic          w_load;
    logic          w_done;

    // Pointers carry one extra wrap bit, so full and empty can be told apart.
    assign w_empty = r_wp == r_rp;
    assign w_full  = (r_wp ^ r_rp) == {1'b1, {PW{1'b0}}};
    assign o_ready = !i_reset && !w_full && !r_ovf;
    assign w_push  = i_start && o_ready;
    assign w_due   = r_state == S_IDLE && !w_empty;
    // The pointer is one bit wider than the RAM address, so it never wraps into low memory.
    assign w_hit   = w_due && r_ptr > LIMIT;
    assign w_issue = w_due && !w_hit;
    assign w_load  = i_load_base && w_empty && (r_state == S_IDLE || r_state == S_HALT);
    assign w_done  = r_flush && w_empty && (r_state == S_IDLE || r_state == S_HALT);

    assign o_mem_we     = w_issue;
    assign o_mem_addr   = r_ptr[AW-1:0];
    assign o_mem_wdata  = w_issue ? r_mem[r_rp[PW-1:0]] : '0;
    assign o_word_count = r_count;
    assign o_done       = w_done;
    assign o_overflow   = r_ovf;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp[PW-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_wcnt  <= '0;
            r_state <= S_IDLE;
            r_flush <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wp    <= r_wp + (PW+1)'(w_push);
            // On overflow the queue is dropped, including any word pushed this same cycle.
            r_rp    <= w_hit ? r_wp + (PW+1)'(w_push) : r_rp + (PW+1)'(w_issue);
            r_ptr   <= w_load ? {1'b0, i_base_addr} : r_ptr + (AW+1)'(w_issue);
            r_count <= w_load ? '0 : r_count + (AW+1)'(w_issue);
            r_ovf   <= !w_load && (r_ovf || w_hit);
            r_flush <= !w_load && (i_flush || (r_flush && !w_done));
            if (w_hit) begin
                r_state <= S_HALT;
            end else if (w_issue) begin
                r_state <= (WR_CYCLES > 1) ? S_WAIT : S_IDLE;
                r_wcnt  <= WAIT_INIT;
            end else if (r_state == S_WAIT && r_wcnt == '0) begin
                r_state <= S_IDLE;
            end else if (r_state == S_WAIT) begin
                r_wcnt  <= r_wcnt - 1'b1;
            end else if (r_state == S_HALT && w_load) begin
                r_state <= S_IDLE;
            end
        end
    end
endmodule
